spi_ram_master: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/spi_ram_master_if.sv | 23 ++
 rtl/spi_ram_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_ram_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM protocol: command encodings, frame
// geometry and the master state encoding.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_TURN,
        ST_RECV,
        ST_GAP
    } state_t;

    // True for the only command that expects a reply byte on miso.
    function automatic logic is_rd_data(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Host-side request/response bundle of the SPI RAM master.
// master modport: the SPI master itself; slave modport: the host driving it.
interface spi_ram_master_if;
    import spi_ram_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cmd;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        input  req_valid, req_cmd, req_data,
        output req_ready, rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_cmd, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the 4-command SPI RAM protocol. One bit per clk cycle,
// frames of {cmd[1:0], data[7:0]} sent MSB first after a one-cycle select
// bit; read-data frames then turn around and capture 8 bits from miso.
// Optional build macro SPI_RAM_MASTER_AUTO_READ_EN: a read-address request
// is followed automatically by a read-data frame and one response.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ram_master_if.master     req_if,
    output logic                 busy,
    output logic                 ss_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam logic [3:0] TURN_INIT = 4'(TURNAROUND);
    localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES - 1);

    state_t               state_q,    state_d;
    logic [FRAME_W-1:0]   frame_q,    frame_d;
    logic [3:0]           bit_cnt_q,  bit_cnt_d;
    logic [3:0]           turn_cnt_q, turn_cnt_d;
    logic [2:0]           rx_cnt_q,   rx_cnt_d;
    logic [DATA_W-1:0]    rx_sr_q,    rx_sr_d;
    logic [3:0]           gap_cnt_q,  gap_cnt_d;
    logic                 ss_n_q,     ss_n_d;
    logic                 mosi_q,     mosi_d;
    logic                 ready_q,    ready_d;
    logic                 busy_q,     busy_d;
    logic                 rsp_vld_q,  rsp_vld_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
    logic                 auto_q,     auto_d;
`endif

    assign req_if.req_ready = ready_q;
    assign req_if.rsp_valid = rsp_vld_q;
    assign req_if.rsp_data  = rsp_data_q;
    assign busy             = busy_q;
    assign ss_n             = ss_n_q;
    assign mosi             = mosi_q;

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        turn_cnt_d = turn_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sr_d    = rx_sr_q;
        gap_cnt_d  = gap_cnt_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        rsp_vld_d  = 1'b0;
        rsp_data_d = rsp_data_q;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
        auto_d     = auto_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid && ready_q) begin
                    frame_d   = {req_if.req_cmd, req_if.req_data};
                    ss_n_d    = 1'b0;
                    mosi_d    = req_if.req_cmd[1];
                    bit_cnt_d = 4'd9;
                    state_d   = ST_SEL;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
                    auto_d    = (req_if.req_cmd == CMD_RD_ADDR);
`endif
                end
            end

            ST_SEL: begin
                mosi_d  = frame_q[bit_cnt_q];
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                // bit_cnt_q is the index of the bit currently on mosi.
                if (bit_cnt_q == 4'd0) begin
                    ss_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    gap_cnt_d = GAP_INIT;
                    state_d   = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    mosi_d    = frame_q[bit_cnt_d];
                    // Leave while bit 0 goes out so that with no turnaround
                    // the first miso sample lands on the following edge.
                    if (bit_cnt_q == 4'd1 && is_rd_data(frame_q[9:8])) begin
                        rx_cnt_d = 3'd0;
                        if (TURNAROUND == 0) begin
                            state_d = ST_RECV;
                        end else begin
                            turn_cnt_d = TURN_INIT;
                            state_d    = ST_TURN;
                        end
                    end
                end
            end

            ST_TURN: begin
                mosi_d     = 1'b0;
                turn_cnt_d = turn_cnt_q - 4'd1;
                if (turn_cnt_q == 4'd1) begin
                    state_d = ST_RECV;
                end
            end

            ST_RECV: begin
                mosi_d   = 1'b0;
                rx_sr_d  = {rx_sr_q[DATA_W-2:0], miso};
                rx_cnt_d = rx_cnt_q + 3'd1;
                if (rx_cnt_q == 3'd7) begin
                    rsp_data_d = rx_sr_d;
                    rsp_vld_d  = 1'b1;
                    ss_n_d     = 1'b1;
                    gap_cnt_d  = GAP_INIT;
                    state_d    = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
                    if (auto_q) begin
                        // Chain the read-data frame using the same payload.
                        auto_d       = 1'b0;
                        frame_d[9:8] = CMD_RD_DATA;
                        ss_n_d       = 1'b0;
                        mosi_d       = CMD_RD_DATA[1];
                        bit_cnt_d    = 4'd9;
                        state_d      = ST_SEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops ss_n and discards the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            turn_cnt_q <= '0;
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            gap_cnt_q  <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
            auto_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sr_q    <= rx_sr_d;
            gap_cnt_q  <= gap_cnt_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
            auto_q     <= auto_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master with a behavioural SPI RAM slave.
// Expected frames and responses are queued when requests are accepted and
// compared when the frame ends / rsp_valid pulses.
module tb_spi_ram_master;

    localparam int TA = 2;
    localparam int G  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy, ss_n, mosi;
    logic miso  = 1'b0;

    spi_ram_master_if bus();

    spi_ram_master #(.TURNAROUND(TA), .GAP_CYCLES(G)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (bus),
        .busy   (busy),
        .ss_n   (ss_n),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [10:0] exp_frames[$];
    logic [7:0]  exp_rsp_data[$];
    int          exp_rsp_cyc[$];

    logic [7:0] slave_ram[256];
    logic [7:0] ref_ram[256];
    logic [7:0] slave_addr = 8'h00;
    logic [7:0] ref_addr   = 8'h00;

    int          fn = 0;
    int          gap_n = 0;
    bit          in_frame = 0;
    bit          first_frame = 1;
    bit          is_rd = 0;
    bit          tail_bad = 0;
    bit          prev_rsp = 0;
    logic [10:0] rec = '0;
    logic [7:0]  rd_byte = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Frame monitor, slave RAM model and response scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            fn = 0; in_frame = 0; first_frame = 1; gap_n = 0; prev_rsp = 0;
            miso = 1'($urandom);
        end else begin
            if (!ss_n) begin
                if (!in_frame) begin
                    if (!first_frame) check("gap_len", (gap_n >= G) ? 1 : 0, 1);
                    in_frame = 1; fn = 0; tail_bad = 0; rec = '0; is_rd = 0;
                end
                check("rdy_busy_in_frame", {30'd0, busy, bus.req_ready}, 32'h2);
                if (fn <= 10) rec[10-fn] = mosi;
                else if (mosi) tail_bad = 1;
                if (fn == 2) begin
                    is_rd = (rec[9:8] == 2'b11);
                    rd_byte = slave_ram[slave_addr];
                end
                if (is_rd && fn >= 10 + TA && fn <= 17 + TA) begin
                    int bi;
                    bi = 17 + TA - fn;
                    miso = rd_byte[bi];
                end else begin
                    miso = 1'($urandom);
                end
                fn++;
            end else begin
                if (in_frame) begin
                    logic [10:0] ef;
                    if (exp_frames.size() == 0) begin
                        check("frame_unexpected", {21'd0, rec}, 32'h7FF_FFFF);
                    end else begin
                        ef = exp_frames.pop_front();
                        check("frame_bits", {21'd0, rec}, {21'd0, ef});
                        check("frame_len", fn, (ef[9:8] == 2'b11) ? 18 + TA : 11);
                        check("frame_tail_mosi0", {31'd0, tail_bad}, 0);
                    end
                    case (rec[9:8])
                        2'b00, 2'b10: slave_addr = rec[7:0];
                        2'b01:        slave_ram[slave_addr] = rec[7:0];
                        default: ;
                    endcase
                    in_frame = 0; first_frame = 0; gap_n = 0;
                end
                gap_n++;
                miso = 1'($urandom);
            end

            if (bus.rsp_valid) begin
                check("rsp_pulse_1cyc", {31'd0, prev_rsp}, 0);
                check("rsp_ss_n_high", {31'd0, ss_n}, 1);
                if (exp_rsp_data.size() == 0) begin
                    check("rsp_unexpected", {24'd0, bus.rsp_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_rsp_data.pop_front()});
                    check("rsp_latency", cyc, exp_rsp_cyc.pop_front());
                end
            end
            prev_rsp = bus.rsp_valid;
        end
    end

    // Drive one request; returns on the negedge after it was accepted.
    task automatic send(input logic [1:0] c, input logic [7:0] d, input bit keep);
        int k;
        int acc;
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_data  = d;
        k = 0;
        while (!bus.req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            check("req_accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        exp_frames.push_back({c[1], c, d});
        case (c)
            2'b00: ref_addr = d;
            2'b01: ref_ram[ref_addr] = d;
            2'b10: begin
                ref_addr = d;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
                exp_frames.push_back({1'b1, 2'b11, d});
                exp_rsp_data.push_back(ref_ram[ref_addr]);
                exp_rsp_cyc.push_back(acc + 11 + G + 18 + TA);
`endif
            end
            default: begin
                exp_rsp_data.push_back(ref_ram[ref_addr]);
                exp_rsp_cyc.push_back(acc + 18 + TA);
            end
        endcase
        @(negedge clk);
        bus.req_cmd  = 2'($urandom);
        bus.req_data = 8'($urandom);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_frames.size() != 0 || exp_rsp_data.size() != 0 || busy || in_frame) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", (k < 2000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            slave_ram[i] = 8'(i * 7 + 3);
            ref_ram[i]   = 8'(i * 7 + 3);
        end
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_data  = 8'h00;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_ss_n", {31'd0, ss_n}, 1);
        check("rst_mosi", {31'd0, mosi}, 0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check("rst_rsp_data", {24'd0, bus.rsp_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_clk", {31'd0, bus.req_ready}, 0);
        @(negedge clk);
        check("ready_after_first_clk", {31'd0, bus.req_ready}, 1);

        // Write address A5
        send(2'b00, 8'hA5, 0);
        wait_idle();
        check("ready_after_gap", {31'd0, bus.req_ready}, 1);

        // Write then read back through the slave RAM
        send(2'b00, 8'h3C, 0);
        send(2'b01, 8'h5A, 0);
        send(2'b10, 8'h3C, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();

        // Reply byte 9B = miso bits 1,0,0,1,1,0,1,1
        slave_ram[8'h20] = 8'h9B;
        ref_ram[8'h20]   = 8'h9B;
        send(2'b10, 8'h20, 0);
        send(2'b11, 8'hFF, 0);
        wait_idle();

        // Back-to-back with req_valid held high
        send(2'b00, 8'h11, 1);
        send(2'b01, 8'hC3, 1);
        send(2'b11, 8'h00, 0);
        wait_idle();

        // Reset in the middle of a read-data frame
        send(2'b11, 8'h00, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ss_n", {31'd0, ss_n}, 1);
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        exp_frames.delete();
        exp_rsp_data.delete();
        exp_rsp_cyc.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_ready_low", {31'd0, bus.req_ready}, 0);
        @(negedge clk);
        send(2'b00, 8'h42, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();

        // Random mix, mostly back-to-back
        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), (i != 7));
        end
        wait_idle();

`ifdef SPI_RAM_MASTER_AUTO_READ_EN
        // Single read-address request becomes two frames and one response
        send(2'b00, 8'h3C, 0);
        send(2'b01, 8'h5A, 0);
        send(2'b10, 8'h3C, 0);
        wait_idle();
`endif

        check("leftover_frames", exp_frames.size(), 0);
        check("leftover_rsp", exp_rsp_data.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
